// File: rtl/apb_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// vmicro16_apb_pkg
//   Shared definitions for the round-robin APB arbiter: the transfer FSM state
//   encoding, reset values, the data word returned to a requester when the
//   watchdog aborts a transfer, and a sizing helper for the watchdog counter.
//   No ports (package).
// -----------------------------------------------------------------------------
package vmicro16_apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam apb_state_e RST_STATE = ST_IDLE;

    // Widest bus the abort constant covers; the arbiter slices what it needs.
    localparam int                       MAX_BUS_WIDTH = 64;
    localparam logic [MAX_BUS_WIDTH-1:0] ABORT_DATA    = '1;

    // Counter must be able to hold TIMEOUT itself; keep at least one bit so a
    // disabled watchdog (TIMEOUT = 0) still elaborates cleanly.
    function automatic int wdt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/apb_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// apb_rr_arbiter_if
//   APB bundle carrying PORTS side-by-side requester lanes; lane i occupies
//   slice [i*BUS_WIDTH +: BUS_WIDTH] of the wide fields and bit i of the
//   1-bit fields. Used with PORTS = MASTER_PORTS on the core side and
//   PORTS = 1 on the shared interconnect side.
//   Signals : PADDR, PWRITE, PSELx, PENABLE, PWDATA  (master -> slave)
//             PRDATA, PREADY                         (slave  -> master)
//   Modports: master (drives the request), slave (answers it)
// -----------------------------------------------------------------------------
interface apb_rr_arbiter_if #(
    parameter int BUS_WIDTH = 16,
    parameter int PORTS     = 1
) ();

    logic [PORTS*BUS_WIDTH-1:0] PADDR;
    logic [PORTS-1:0]           PWRITE;
    logic [PORTS-1:0]           PSELx;
    logic [PORTS-1:0]           PENABLE;
    logic [PORTS*BUS_WIDTH-1:0] PWDATA;
    logic [PORTS*BUS_WIDTH-1:0] PRDATA;
    logic [PORTS-1:0]           PREADY;

    modport master (
        output PADDR, PWRITE, PSELx, PENABLE, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PWRITE, PSELx, PENABLE, PWDATA,
        output PRDATA, PREADY
    );

endinterface

// File: rtl/apb_rr_arbiter_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
//   Combinational round-robin selector. Returns the first set request bit
//   found searching upward from i_last+1 with wrap-around, so the previously
//   granted requester is considered last.
//   i_req   in  MASTER_PORTS  request vector
//   i_last  in  IDX_W         index granted most recently
//   o_idx   out IDX_W         chosen index (0 when nothing requested)
//   o_valid out 1             at least one request present
// -----------------------------------------------------------------------------
module rr_priority_picker
    import vmicro16_apb_pkg::*;
#(
    parameter  int MASTER_PORTS = 4,
    localparam int IDX_W        = $clog2(MASTER_PORTS)
) (
    input  logic [MASTER_PORTS-1:0] i_req,
    input  logic [IDX_W-1:0]        i_last,
    output logic [IDX_W-1:0]        o_idx,
    output logic                    o_valid
);

    always_comb begin
        logic [IDX_W-1:0] w_cand;
        w_cand  = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        // Scan from the farthest candidate (i_last itself) back toward
        // i_last+1; later hits overwrite earlier ones, so the nearest wins.
        for (int k = MASTER_PORTS; k >= 1; k--) begin
            w_cand = IDX_W'((int'(i_last) + k) % MASTER_PORTS);
            if (i_req[w_cand]) begin
                o_idx   = w_cand;
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// apb_rr_arbiter
//   Shares one APB master port between MASTER_PORTS requesting cores using
//   round-robin priority. A chosen request is latched and replayed on the
//   shared port as SETUP then ACCESS; completion (PREADY/PRDATA) is routed
//   back only to the granted core. A watchdog aborts an ACCESS phase that has
//   waited TIMEOUT cycles, returning all-ones data and pulsing ERR_TIMEOUT.
//   clk          in   clock, rising edge
//   reset        in   asynchronous, active-low reset
//   s_apb        slave  modport, MASTER_PORTS requester lanes
//   m_apb        master modport, shared interconnect port (one lane)
//   GRANT        out  index of the current or last granted requester
//   ERR_TIMEOUT  out  one-cycle pulse when the watchdog aborts a transfer
// -----------------------------------------------------------------------------
module apb_rr_arbiter
    import vmicro16_apb_pkg::*;
#(
    parameter int BUS_WIDTH    = 16,
    parameter int MASTER_PORTS = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                            clk,
    input  logic                            reset,
    apb_rr_arbiter_if.slave                 s_apb,
    apb_rr_arbiter_if.master                m_apb,
    output logic [$clog2(MASTER_PORTS)-1:0] GRANT,
    output logic                            ERR_TIMEOUT
);

    localparam int              GW        = $clog2(MASTER_PORTS);
    localparam int              WW        = wdt_width(TIMEOUT);
    localparam logic [GW-1:0]   RST_LAST  = GW'(MASTER_PORTS - 1);
    localparam logic [WW-1:0]   WDT_LIMIT = WW'(TIMEOUT);

    apb_state_e                      r_state;
    apb_state_e                      w_state_nxt;
    logic [GW-1:0]                   r_grant;
    logic [GW-1:0]                   r_last;
    logic [BUS_WIDTH-1:0]            r_paddr;
    logic [BUS_WIDTH-1:0]            r_pwdata;
    logic                            r_pwrite;
    logic [WW-1:0]                   r_wdt;

    logic [GW-1:0]                   w_pick_idx;
    logic                            w_pick_valid;
    logic                            w_timeout;
    logic                            w_done;
    logic [MASTER_PORTS-1:0]         w_s_pready;
    logic [MASTER_PORTS*BUS_WIDTH-1:0] w_s_prdata;
    logic                            w_unused_penable;

    rr_priority_picker #(
        .MASTER_PORTS (MASTER_PORTS)
    ) u_picker (
        .i_req   (s_apb.PSELx),
        .i_last  (r_last),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // Requester PENABLE carries no information here: the arbiter generates
    // its own SETUP/ACCESS sequence from PSELx alone.
    assign w_unused_penable = ^s_apb.PENABLE;

    // Abort only when the slave is still not ready in the cycle the count has
    // already reached TIMEOUT; a late PREADY in that same cycle still wins.
    assign w_timeout = (TIMEOUT != 0) && (r_state == ST_ACCESS)
                       && !m_apb.PREADY[0] && (r_wdt == WDT_LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RST_STATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_s_pready  = '0;
        w_s_prdata  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (m_apb.PREADY[0] || w_timeout) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Return path is combinational so the core sees completion in the
        // same cycle the shared slave signals it.
        if (w_done) begin
            w_s_pready[r_grant] = 1'b1;
            w_s_prdata[r_grant*BUS_WIDTH +: BUS_WIDTH] =
                m_apb.PREADY[0] ? m_apb.PRDATA : ABORT_DATA[BUS_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant  <= '0;
            r_last   <= RST_LAST;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pwrite <= 1'b0;
            r_wdt    <= '0;
        end else begin
            // Latch the winner's request so later changes on its lane (even a
            // dropped PSELx) cannot disturb the transfer in flight.
            if ((r_state == ST_IDLE) && w_pick_valid) begin
                r_grant  <= w_pick_idx;
                r_last   <= w_pick_idx;
                r_paddr  <= s_apb.PADDR[w_pick_idx*BUS_WIDTH +: BUS_WIDTH];
                r_pwdata <= s_apb.PWDATA[w_pick_idx*BUS_WIDTH +: BUS_WIDTH];
                r_pwrite <= s_apb.PWRITE[w_pick_idx];
            end
            // SETUP is the only way into ACCESS, so clearing here clears on
            // entry; the count saturates at TIMEOUT instead of wrapping.
            if (r_state == ST_SETUP) begin
                r_wdt <= '0;
            end else if ((TIMEOUT != 0) && (r_state == ST_ACCESS)
                         && !m_apb.PREADY[0] && (r_wdt != WDT_LIMIT)) begin
                r_wdt <= r_wdt + WW'(1);
            end
        end
    end

    assign m_apb.PSELx   = (r_state != ST_IDLE);
    assign m_apb.PENABLE = (r_state == ST_ACCESS);
    assign m_apb.PADDR   = r_paddr;
    assign m_apb.PWRITE  = r_pwrite;
    assign m_apb.PWDATA  = r_pwdata;

    assign s_apb.PREADY  = w_s_pready;
    assign s_apb.PRDATA  = w_s_prdata;

    assign GRANT         = r_grant;
    assign ERR_TIMEOUT   = w_timeout;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_rr_arbiter
//   Directed bench for apb_rr_arbiter (4 requesters, 16-bit bus, TIMEOUT 8).
//   Stimulus pushes the expected completion (requester, data, abort flag,
//   cycle) into a scoreboard; a negedge monitor pops and compares whenever
//   any requester sees PREADY. Shared-port signals are checked in-line.
// -----------------------------------------------------------------------------
module tb_apb_rr_arbiter;

    localparam int BW = 16;
    localparam int NP = 4;
    localparam int TO = 8;

    typedef struct {
        int          idx;
        logic [15:0] data;
        bit          err;
        int          cyc;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  grant;
    logic        err_timeout;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          reqs_left [NP];
    logic [3:0]  done_mask = '0;
    exp_t        sb [$];

    int          acc_cnt     = 0;
    int          slave_waits = 0;
    bit          slave_never = 1'b0;
    logic [15:0] slave_rdata = '0;

    apb_rr_arbiter_if #(.BUS_WIDTH(BW), .PORTS(NP)) s_if ();
    apb_rr_arbiter_if #(.BUS_WIDTH(BW), .PORTS(1))  m_if ();

    apb_rr_arbiter #(
        .BUS_WIDTH    (BW),
        .MASTER_PORTS (NP),
        .TIMEOUT      (TO)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .s_apb       (s_if.slave),
        .m_apb       (m_if.master),
        .GRANT       (grant),
        .ERR_TIMEOUT (err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Shared-side slave: ready after slave_waits ACCESS cycles, or never.
    always @(posedge clk) begin
        if (m_if.PSELx[0] && m_if.PENABLE[0] && !m_if.PREADY[0]) acc_cnt <= acc_cnt + 1;
        else                                                      acc_cnt <= 0;
    end
    assign m_if.PREADY[0] = m_if.PSELx[0] && m_if.PENABLE[0] && !slave_never
                            && (acc_cnt >= slave_waits);
    assign m_if.PRDATA    = slave_rdata;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Completion monitor.
    always @(negedge clk) begin
        exp_t        e;
        logic [63:0] exp_vec;
        done_mask = s_if.PREADY;
        if (rst_n) begin
            if (s_if.PREADY != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_pready", 64'(s_if.PREADY), 64'd0);
                end else begin
                    e       = sb.pop_front();
                    exp_vec = '0;
                    exp_vec[e.idx*BW +: BW] = e.data;
                    check("pready_vec",   64'(s_if.PREADY), 64'd1 << e.idx);
                    check("prdata_vec",   64'(s_if.PRDATA), exp_vec);
                    check("grant",        64'(grant),       64'(e.idx));
                    check("err_timeout",  64'(err_timeout), 64'(e.err));
                    check("pready_cycle", 64'(cyc),         64'(e.cyc));
                end
            end else if (err_timeout) begin
                check("err_without_pready", 64'(err_timeout), 64'd0);
            end
        end
    end

    function automatic bit busy();
        bit b;
        b = (sb.size() != 0);
        for (int i = 0; i < NP; i++) if (reqs_left[i] > 0) b = 1'b1;
        return b;
    endfunction

    // Advance one cycle; requesters hold PSELx until their requested number
    // of transfers has completed.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (done_mask[i] && reqs_left[i] > 0) reqs_left[i]--;
            s_if.PSELx[i] = (reqs_left[i] > 0);
        end
    endtask

    task automatic start_req(input int i, input logic [15:0] a, input bit w,
                             input logic [15:0] wd, input int cnt);
        s_if.PADDR[i*BW +: BW]  = a;
        s_if.PWRITE[i]          = w;
        s_if.PWDATA[i*BW +: BW] = wd;
        reqs_left[i]            = cnt;
        s_if.PSELx[i]           = 1'b1;
    endtask

    task automatic push(input int i, input logic [15:0] d, input bit e, input int c);
        exp_t x;
        x.idx  = i;
        x.data = d;
        x.err  = e;
        x.cyc  = c;
        sb.push_back(x);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy() && k < budget) begin
            tick();
            k++;
        end
        check("drain_in_budget", 64'(busy()), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_m_psel"},    64'(m_if.PSELx),   64'd0);
        check({tag, "_m_penable"}, 64'(m_if.PENABLE), 64'd0);
        check({tag, "_m_paddr"},   64'(m_if.PADDR),   64'd0);
        check({tag, "_m_pwrite"},  64'(m_if.PWRITE),  64'd0);
        check({tag, "_m_pwdata"},  64'(m_if.PWDATA),  64'd0);
        check({tag, "_s_pready"},  64'(s_if.PREADY),  64'd0);
        check({tag, "_s_prdata"},  64'(s_if.PRDATA),  64'd0);
        check({tag, "_err"},       64'(err_timeout),  64'd0);
        check({tag, "_grant"},     64'(grant),        64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        s_if.PADDR   = '0;
        s_if.PWRITE  = '0;
        s_if.PSELx   = '0;
        s_if.PENABLE = '0;
        s_if.PWDATA  = '0;
        for (int i = 0; i < NP; i++) reqs_left[i] = 0;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        tick();
        rst_n = 1'b1;

        // Single requester 2 read, zero-wait slave
        tick();
        n = cyc;
        slave_rdata = 16'h1234;
        start_req(2, 16'h0085, 1'b0, 16'h0000, 1);
        push(2, 16'h1234, 1'b0, n + 2);
        tick();
        check("t1_psel_n1",    64'(m_if.PSELx),   64'd1);
        check("t1_penable_n1", 64'(m_if.PENABLE), 64'd0);
        check("t1_paddr_n1",   64'(m_if.PADDR),   64'h0085);
        check("t1_grant_n1",   64'(grant),        64'd2);
        tick();
        check("t1_psel_n2",    64'(m_if.PSELx),   64'd1);
        check("t1_penable_n2", 64'(m_if.PENABLE), 64'd1);
        wait_idle(20);

        // All four requesting continuously after reset: 0,1,2,3,0,1
        do_reset();
        tick();
        n = cyc;
        slave_rdata = 16'h00C3;
        start_req(0, 16'h0010, 1'b0, 16'h0000, 2);
        start_req(1, 16'h0011, 1'b0, 16'h0000, 2);
        start_req(2, 16'h0012, 1'b0, 16'h0000, 1);
        start_req(3, 16'h0013, 1'b0, 16'h0000, 1);
        push(0, 16'h00C3, 1'b0, n + 2);
        push(1, 16'h00C3, 1'b0, n + 5);
        push(2, 16'h00C3, 1'b0, n + 8);
        push(3, 16'h00C3, 1'b0, n + 11);
        push(0, 16'h00C3, 1'b0, n + 14);
        push(1, 16'h00C3, 1'b0, n + 17);
        wait_idle(60);

        // Requesters 1 and 3 with last = 1: 3 first, then 1
        check("t3_last_is_1", 64'(grant), 64'd1);
        tick();
        n = cyc;
        slave_rdata = 16'h3131;
        start_req(1, 16'h0021, 1'b0, 16'h0000, 1);
        start_req(3, 16'h0023, 1'b0, 16'h0000, 1);
        push(3, 16'h3131, 1'b0, n + 2);
        push(1, 16'h3131, 1'b0, n + 5);
        wait_idle(30);

        // Write with four slave wait states
        tick();
        n = cyc;
        slave_waits = 4;
        slave_rdata = 16'h5555;
        start_req(0, 16'h00A0, 1'b1, 16'hBEEF, 1);
        push(0, 16'h5555, 1'b0, n + 6);
        for (int c = 1; c <= 6; c++) begin
            tick();
            check("t4_pwdata",  64'(m_if.PWDATA),  64'hBEEF);
            check("t4_psel",    64'(m_if.PSELx),   64'd1);
            check("t4_penable", 64'(m_if.PENABLE), 64'(c >= 2));
        end
        check("t4_pwrite", 64'(m_if.PWRITE), 64'd1);
        wait_idle(20);
        slave_waits = 0;

        // Watchdog abort: slave never ready
        tick();
        n = cyc;
        slave_never = 1'b1;
        start_req(3, 16'h0030, 1'b0, 16'h0000, 1);
        push(3, 16'hFFFF, 1'b1, n + 10);
        repeat (10) tick();
        tick();
        check("t5_idle_psel", 64'(m_if.PSELx),  64'd0);
        check("t5_err_clear", 64'(err_timeout), 64'd0);
        wait_idle(10);

        // Reset mid-ACCESS, then requester 0 beats 1
        tick();
        n = cyc;
        start_req(1, 16'h0040, 1'b0, 16'h0000, 1);
        repeat (3) tick();
        check("t6_in_access", 64'(m_if.PENABLE), 64'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        reqs_left[1]  = 0;
        s_if.PSELx    = '0;
        slave_never   = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        n = cyc;
        slave_rdata = 16'h6060;
        start_req(0, 16'h0050, 1'b0, 16'h0000, 1);
        start_req(1, 16'h0051, 1'b0, 16'h0000, 1);
        push(0, 16'h6060, 1'b0, n + 2);
        push(1, 16'h6060, 1'b0, n + 5);
        wait_idle(30);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
